const_bank_table: RTL and testbench
===================================

Name: const_bank_table

Overview:
- Parametrised successor to the per-problem constant lookup used by the immediate/constant-load path of the core.
- Holds NUM_BANKS banks of DEPTH constants each, WIDTH bits per constant.
- After reset, an init sweep loads the package defaults. The table is then runtime-writable and can be reloaded on request.
- Reads are registered, with ready/valid and an error flag; the control unit's Num_put_idx datapath consumes rd_data.

Parameters:
- NUM_BANKS, 4: number of constant banks; one bank per problem/program.
- DEPTH, 8: entries per bank; must be a power of two, minimum 2.
- WIDTH, 8: constant width in bits.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous active-low reset.
- reload  in  1  one-cycle pulse; re-runs the default-load sweep.
- rd_en  in  1  read request.
- rd_bank  in  $clog2(NUM_BANKS)  bank to read.
- rd_idx  in  $clog2(DEPTH)  entry to read.
- rd_ready  out  1  high when a read can be accepted.
- rd_valid  out  1  rd_data/rd_err valid this cycle (one-cycle pulse).
- rd_data  out  WIDTH  constant read out.
- rd_err  out  1  read targeted a bank outside the valid range.
- wr_en  in  1  write request.
- wr_bank  in  $clog2(NUM_BANKS)  bank to write.
- wr_idx  in  $clog2(DEPTH)  entry to write.
- wr_data  in  WIDTH  value to write.
- wr_err  out  1  one-cycle pulse: write rejected.
- init_done  out  1  high when state is RUN.

Behaviour:
- Clocking and reset (already decided): one clock, Clk; reset is synchronous and active-low, Reset_n.
- FSM states: INIT and RUN.
- While Reset_n=0:
  - state <= INIT, ptr <= 0.
  - rd_valid, rd_err, wr_err <= 0; rd_data <= 0.
  - Memory contents are undefined until the sweep runs.
- INIT state:
  - Each cycle, every bank b is written in parallel: mem[b][ptr] <= DEFAULT[b][ptr].
  - Banks with b >= NUM_DEFAULT_BANKS are loaded with 0.
  - ptr increments each cycle; when ptr==DEPTH-1 the state goes to RUN on that edge.
  - Timing: first edge with Reset_n=1 writes entry 0. init_done rises after edge DEPTH, so DEPTH=8 gives 8 cycles.
  - rd_ready=0 throughout. rd_en is ignored and gives no rd_valid.
  - wr_en is rejected with a wr_err pulse next cycle; memory is not written.
- RUN state:
  - rd_ready = 1 (combinational: state==RUN).
  - reload=1 → state <= INIT, ptr <= 0. Any same-cycle rd_en is still served; any same-cycle wr_en is dropped with a wr_err pulse.
- Read path (RUN), latency 1:
  - rd_en sampled at edge N; rd_valid=1 for the cycle after edge N.
  - Valid bank: rd_data = mem[rd_bank][rd_idx], rd_err=0.
  - rd_bank >= NUM_BANKS: rd_data=0, rd_err=1, rd_valid=1.
  - Back-to-back reads: one result per cycle, no bubbles.
- Write path (RUN):
  - wr_en with wr_bank < NUM_BANKS → mem written at the edge.
  - wr_bank >= NUM_BANKS → no write; wr_err=1 for the following cycle.
- Simultaneous read and write to the same bank/idx in the same cycle: write-first; rd_data returns wr_data.
- Between reads, rd_data holds its last value and rd_valid=0; rd_err clears with rd_valid.
- Reset asserted mid-sweep or mid-read: reset wins; any in-flight rd_valid is suppressed and the sweep restarts from ptr=0.
- Index width is exact, so no idx range check is needed; ptr wraps naturally, but the FSM leaves INIT before any wrap.

Decomposition:
- Package const_table_pkg:
  - Localparams NUM_DEFAULT_BANKS=3, DEF_DEPTH=8.
  - typedef enum logic {INIT, RUN} ct_state_t.
  - DEFAULT table:
    - bank0 = {0,1,2,8,10,14,128,255}
    - bank1 = {0,1,2,8,10,15,128,255}
    - bank2 = {0,1,2,3,4,6,64,128}
  - Entries beyond DEF_DEPTH load as 0.
- One sub-module, ct_init_seq: the INIT/RUN FSM plus ptr counter. Outputs init_we, init_ptr, init_done.
- The storage array and read/write muxing stay in the top module.

Test Plan:
- Reset then idle → init_done low for exactly 8 cycles after Reset_n rises, high on the 9th; rd_ready tracks init_done.
- After init, read bank1 idx5 → one cycle later rd_valid=1, rd_data=15, rd_err=0. Read bank2 idx6 → 64.
- Write bank0 idx3 = 0xA5, then read it → 0xA5. Same-cycle write bank0 idx4 = 0x3C plus read bank0 idx4 → rd_data=0x3C (bypass).
- Read bank3 (no defaults) → 0. With NUM_BANKS=3, read bank3 → rd_err=1, rd_data=0. Write bank3 → wr_err pulse, and a later read of bank0 is unaffected.
- Write bank0 idx3 = 0xA5, pulse reload, wait 8 cycles, read bank0 idx3 → 8 (default restored). rd_en during the sweep → no rd_valid.
- Assert Reset_n=0 at sweep cycle 4 for 1 cycle → sweep restarts and init_done comes 8 cycles after release. Read issued the cycle before reset → no rd_valid.

Source files
------------

// File: rtl/const_table_pkg.sv
// Shared types, default constant table and lookup helper for the constant bank table.
package const_table_pkg;

    localparam int NUM_DEFAULT_BANKS = 3;
    localparam int DEF_DEPTH         = 8;

    typedef enum logic {INIT, RUN} ct_state_t;

    localparam logic [7:0] DEFAULT_TABLE [NUM_DEFAULT_BANKS][DEF_DEPTH] = '{
        '{8'd0, 8'd1, 8'd2, 8'd8, 8'd10, 8'd14, 8'd128, 8'd255},
        '{8'd0, 8'd1, 8'd2, 8'd8, 8'd10, 8'd15, 8'd128, 8'd255},
        '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4,  8'd6,  8'd64,  8'd128}
    };

    // Banks or entries outside the default table load as zero.
    function automatic logic [7:0] default_value(input int unsigned bank, input int unsigned idx);
        logic [7:0] value;
        value = 8'd0;
        if (bank < NUM_DEFAULT_BANKS && idx < DEF_DEPTH) begin
            value = DEFAULT_TABLE[bank[1:0]][idx[2:0]];
        end
        return value;
    endfunction

endpackage

// File: rtl/const_bank_table_if.sv
// Read/write/control bus of the constant bank table.
interface const_bank_table_if #(
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              reload;
    logic              rd_en;
    logic [BANK_W-1:0] rd_bank;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_ready;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_err;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_err;
    logic              init_done;

    modport master (
        output reload, rd_en, rd_bank, rd_idx, wr_en, wr_bank, wr_idx, wr_data,
        input  rd_ready, rd_valid, rd_data, rd_err, wr_err, init_done
    );

    modport slave (
        input  reload, rd_en, rd_bank, rd_idx, wr_en, wr_bank, wr_idx, wr_data,
        output rd_ready, rd_valid, rd_data, rd_err, wr_err, init_done
    );

endinterface

// File: rtl/ct_init_seq.sv
// INIT/RUN sequencer: sweeps a pointer across every entry to load defaults, then idles in RUN.
module ct_init_seq
    import const_table_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     reload,
    output logic                     init_we,
    output logic [$clog2(DEPTH)-1:0] init_ptr,
    output logic                     init_done
);

    localparam int PTR_W = $clog2(DEPTH);

    ct_state_t        state, state_next;
    logic [PTR_W-1:0] ptr, ptr_next;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // The pointer wraps to zero on the same edge that leaves INIT.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            INIT: begin
                ptr_next = ptr + 1'b1;
                if (ptr == PTR_W'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_next = INIT;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                ptr_next   = '0;
            end
        endcase
    end

    assign init_we   = (state == INIT);
    assign init_done = (state == RUN);
    assign init_ptr  = ptr;

endmodule

// File: rtl/const_bank_table.sv
// Banked constant table with a default-load sweep, runtime writes and registered reads.
module const_bank_table
    import const_table_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    const_bank_table_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic             init_we;
    logic             init_done;
    logic [IDX_W-1:0] init_ptr;
    logic             run;
    logic             rd_bank_ok;
    logic             wr_bank_ok;
    logic             wr_accept;
    logic             wr_reject;
    logic             bypass;
    logic [WIDTH-1:0] bank_rd [NUM_BANKS];

    ct_init_seq #(.DEPTH(DEPTH)) u_init_seq (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .reload    (bus.reload),
        .init_we   (init_we),
        .init_ptr  (init_ptr),
        .init_done (init_done)
    );

    assign run           = init_done;
    assign bus.rd_ready  = run;
    assign bus.init_done = init_done;

    assign rd_bank_ok = 32'(bus.rd_bank) < NUM_BANKS;
    assign wr_bank_ok = 32'(bus.wr_bank) < NUM_BANKS;
    // A reload in the same cycle drops the write so the sweep starts from a clean table.
    assign wr_accept  = run && !bus.reload && bus.wr_en && wr_bank_ok;
    assign wr_reject  = bus.wr_en && !wr_accept;
    assign bypass     = wr_accept && (bus.wr_bank == bus.rd_bank) && (bus.wr_idx == bus.rd_idx);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge Clk) begin
            if (init_we) begin
                mem[init_ptr] <= WIDTH'(default_value(b, 32'(init_ptr)));
            end else if (wr_accept && 32'(bus.wr_bank) == b) begin
                mem[bus.wr_idx] <= bus.wr_data;
            end
        end

        assign bank_rd[b] = mem[bus.rd_idx];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.wr_err   <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.wr_err   <= wr_reject;
            if (run && bus.rd_en) begin
                bus.rd_valid <= 1'b1;
                if (!rd_bank_ok) begin
                    bus.rd_data <= '0;
                    bus.rd_err  <= 1'b1;
                end else if (bypass) begin
                    bus.rd_data <= bus.wr_data;
                end else begin
                    bus.rd_data <= bank_rd[bus.rd_bank];
                end
            end
        end
    end

endmodule

// File: tb/tb_const_bank_table.sv
// Scoreboard bench for const_bank_table: a 4-bank instance for the main paths, a 3-bank one for range errors.
module tb_const_bank_table;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic Clk;
    logic Reset_n;

    int   checks;
    int   errors;
    exp_t q4[$];
    exp_t q3[$];
    int   wr_pending4;
    int   wr_pending3;

    const_bank_table_if #(.NUM_BANKS(4), .DEPTH(8), .WIDTH(8)) bus4 ();
    const_bank_table_if #(.NUM_BANKS(3), .DEPTH(8), .WIDTH(8)) bus3 ();

    const_bank_table #(.NUM_BANKS(4), .DEPTH(8), .WIDTH(8)) dut4 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus4)
    );

    const_bank_table #(.NUM_BANKS(3), .DEPTH(8), .WIDTH(8)) dut3 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pops one expected response; every wr_err consumes one expected reject.
    always @(negedge Clk) begin
        exp_t e;
        if (bus4.rd_valid === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd4_unexpected: got rd_valid=1 data=%0h, expected no response", bus4.rd_data);
            end else begin
                e = q4.pop_front();
                if (bus4.rd_data !== e.data || bus4.rd_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL rd4_data: got data=%0h err=%0b, expected data=%0h err=%0b",
                             bus4.rd_data, bus4.rd_err, e.data, e.err);
                end
            end
        end
        if (bus3.rd_valid === 1'b1) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd3_unexpected: got rd_valid=1 data=%0h, expected no response", bus3.rd_data);
            end else begin
                e = q3.pop_front();
                if (bus3.rd_data !== e.data || bus3.rd_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL rd3_data: got data=%0h err=%0b, expected data=%0h err=%0b",
                             bus3.rd_data, bus3.rd_err, e.data, e.err);
                end
            end
        end
        if (bus4.wr_err === 1'b1) begin
            checks++;
            if (wr_pending4 == 0) begin
                errors++;
                $display("[TB] FAIL wr4_err_unexpected: got wr_err=1, expected 0");
            end else begin
                wr_pending4--;
            end
        end
        if (bus3.wr_err === 1'b1) begin
            checks++;
            if (wr_pending3 == 0) begin
                errors++;
                $display("[TB] FAIL wr3_err_unexpected: got wr_err=1, expected 0");
            end else begin
                wr_pending3--;
            end
        end
    end

    task automatic read4(input logic [1:0] bank, input logic [2:0] idx, input logic [7:0] data, input logic err);
        bus4.rd_en   = 1'b1;
        bus4.rd_bank = bank;
        bus4.rd_idx  = idx;
        q4.push_back('{data: data, err: err});
        @(negedge Clk);
        bus4.rd_en = 1'b0;
    endtask

    task automatic write4(input logic [1:0] bank, input logic [2:0] idx, input logic [7:0] data);
        bus4.wr_en   = 1'b1;
        bus4.wr_bank = bank;
        bus4.wr_idx  = idx;
        bus4.wr_data = data;
        @(negedge Clk);
        bus4.wr_en = 1'b0;
    endtask

    task automatic read3(input logic [1:0] bank, input logic [2:0] idx, input logic [7:0] data, input logic err);
        bus3.rd_en   = 1'b1;
        bus3.rd_bank = bank;
        bus3.rd_idx  = idx;
        q3.push_back('{data: data, err: err});
        @(negedge Clk);
        bus3.rd_en = 1'b0;
    endtask

    task automatic wait_init(input string name, input int cycles);
        for (int j = 1; j <= cycles; j++) begin
            @(negedge Clk);
            check_output({name, "_init_done"}, 32'(bus4.init_done), 32'(j == cycles));
            check_output({name, "_rd_ready"}, 32'(bus4.rd_ready), 32'(j == cycles));
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        wr_pending4 = 0;
        wr_pending3 = 0;
        Reset_n     = 1'b0;
        {bus4.reload, bus4.rd_en, bus4.wr_en} = 3'b000;
        {bus4.rd_bank, bus4.rd_idx, bus4.wr_bank, bus4.wr_idx, bus4.wr_data} = '0;
        {bus3.reload, bus3.rd_en, bus3.wr_en} = 3'b000;
        {bus3.rd_bank, bus3.rd_idx, bus3.wr_bank, bus3.wr_idx, bus3.wr_data} = '0;

        repeat (3) @(negedge Clk);
        check_output("reset_rd_valid", 32'(bus4.rd_valid), 32'd0);
        check_output("reset_rd_data", 32'(bus4.rd_data), 32'd0);
        check_output("reset_init_done", 32'(bus4.init_done), 32'd0);

        Reset_n = 1'b1;
        wait_init("boot", 8);
        check_output("boot3_init_done", 32'(bus3.init_done), 32'd1);

        read4(2'd1, 3'd5, 8'd15, 1'b0);
        read4(2'd2, 3'd6, 8'd64, 1'b0);
        @(negedge Clk);
        check_output("hold_rd_valid", 32'(bus4.rd_valid), 32'd0);
        check_output("hold_rd_data", 32'(bus4.rd_data), 32'd64);
        check_output("hold_rd_err", 32'(bus4.rd_err), 32'd0);

        write4(2'd0, 3'd3, 8'hA5);
        read4(2'd0, 3'd3, 8'hA5, 1'b0);

        // Same-cycle write and read of one entry returns the new data.
        bus4.wr_en   = 1'b1;
        bus4.wr_bank = 2'd0;
        bus4.wr_idx  = 3'd4;
        bus4.wr_data = 8'h3C;
        read4(2'd0, 3'd4, 8'h3C, 1'b0);
        bus4.wr_en = 1'b0;
        read4(2'd0, 3'd4, 8'h3C, 1'b0);

        read4(2'd3, 3'd2, 8'd0, 1'b0);

        // Reload with a same-cycle read (served) and write (rejected).
        bus4.reload  = 1'b1;
        bus4.wr_en   = 1'b1;
        bus4.wr_bank = 2'd1;
        bus4.wr_idx  = 3'd0;
        bus4.wr_data = 8'h99;
        wr_pending4++;
        read4(2'd2, 3'd7, 8'd128, 1'b0);
        bus4.reload  = 1'b0;
        bus4.wr_en   = 1'b0;
        check_output("reload_init_done", 32'(bus4.init_done), 32'd0);
        bus4.rd_en   = 1'b1;
        bus4.rd_bank = 2'd0;
        bus4.rd_idx  = 3'd0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge Clk);
            check_output("reload_init_done", 32'(bus4.init_done), 32'(j == 8));
            if (j == 3) begin
                bus4.rd_en   = 1'b0;
                bus4.wr_en   = 1'b1;
                bus4.wr_bank = 2'd0;
                bus4.wr_idx  = 3'd1;
                bus4.wr_data = 8'h77;
                wr_pending4++;
            end else if (j == 4) begin
                bus4.wr_en = 1'b0;
            end
        end

        read4(2'd0, 3'd3, 8'd8, 1'b0);
        read4(2'd0, 3'd4, 8'd10, 1'b0);
        read4(2'd0, 3'd1, 8'd1, 1'b0);
        read4(2'd1, 3'd0, 8'd0, 1'b0);

        // Reset while a read is being sampled: no response may appear.
        bus4.rd_en   = 1'b1;
        bus4.rd_bank = 2'd1;
        bus4.rd_idx  = 3'd7;
        Reset_n      = 1'b0;
        @(negedge Clk);
        bus4.rd_en = 1'b0;
        check_output("rst_read_valid", 32'(bus4.rd_valid), 32'd0);
        check_output("rst_read_data", 32'(bus4.rd_data), 32'd0);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        check_output("midsweep_init_done", 32'(bus4.init_done), 32'd0);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        check_output("midsweep_rst_init_done", 32'(bus4.init_done), 32'd0);
        wait_init("restart", 8);
        read4(2'd1, 3'd5, 8'd15, 1'b0);
        read4(2'd2, 3'd0, 8'd0, 1'b0);

        read3(2'd3, 3'd0, 8'd0, 1'b1);
        read3(2'd2, 3'd7, 8'd128, 1'b0);
        bus3.wr_en   = 1'b1;
        bus3.wr_bank = 2'd3;
        bus3.wr_idx  = 3'd1;
        bus3.wr_data = 8'h77;
        wr_pending3++;
        @(negedge Clk);
        bus3.wr_en = 1'b0;
        read3(2'd0, 3'd1, 8'd1, 1'b0);
        read3(2'd1, 3'd5, 8'd15, 1'b0);

        repeat (3) @(negedge Clk);
        check_output("q4_drained", 32'(q4.size()), 32'd0);
        check_output("q3_drained", 32'(q3.size()), 32'd0);
        check_output("wr4_err_seen", 32'(wr_pending4), 32'd0);
        check_output("wr3_err_seen", 32'(wr_pending3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
